clock_phase_monitor: RTL and testbench

Receiver-side checker for the four-phase one-hot CPU clock bus `clk[0:3]` produced by the clock generator. It samples the phase vector on a fast system clock and tracks the current phase and completed revolutions. It flags malformed, out-of-order or stalled phase sequences. It sits beside the sequencer and gives it a qualified phase index plus a `locked` status, so the design never acts on a glitched phase.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/clock_phase_monitor_if.sv | 26 ++
 rtl/phase_decode.sv | 22 ++
 rtl/clock_phase_monitor.sv | 135 +++++++++++++
 tb/tb_clock_phase_monitor.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared phase encodings, monitor states and phase helper
package clock_pkg;

    localparam logic [0:3] PH0 = 4'b1000;
    localparam logic [0:3] PH1 = 4'b0100;
    localparam logic [0:3] PH2 = 4'b0010;
    localparam logic [0:3] PH3 = 4'b0001;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKING,
        LOCKED,
        FAULT
    } mon_state_t;

    // Rotate right in [0:3] order, so PH3 wraps back to PH0.
    function automatic logic [0:3] next_phase(input logic [0:3] ph);
        return {ph[3], ph[0:2]};
    endfunction

endpackage

// File: rtl/clock_phase_monitor_if.sv
// rtl/clock_phase_monitor_if.sv - phase bus input and monitor status bundle
interface clock_phase_monitor_if #(
    parameter int CNT_W = 16
);
    logic [0:3]       phase_in;
    logic             clear_err;
    logic [1:0]       cur_phase;
    logic             phase_strobe;
    logic             locked;
    logic [CNT_W-1:0] rev_count;
    logic             err_onehot;
    logic             err_order;
    logic             err_stall;

    modport master (
        output phase_in, clear_err,
        input  cur_phase, phase_strobe, locked, rev_count,
               err_onehot, err_order, err_stall
    );

    modport slave (
        input  phase_in, clear_err,
        output cur_phase, phase_strobe, locked, rev_count,
               err_onehot, err_order, err_stall
    );
endinterface

// File: rtl/phase_decode.sv
// rtl/phase_decode.sv - one-hot phase vector to index plus valid flag
module phase_decode
    import clock_pkg::*;
(
    input  logic [0:3] onehot,
    output logic [1:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = 2'd0;
        valid = 1'b1;
        case (onehot)
            PH0:     idx = 2'd0;
            PH1:     idx = 2'd1;
            PH2:     idx = 2'd2;
            PH3:     idx = 2'd3;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/clock_phase_monitor.sv
// rtl/clock_phase_monitor.sv - four-phase clock bus checker with lock tracking
module clock_phase_monitor
    import clock_pkg::*;
#(
    parameter int LOCK_REVS = 2,
    parameter int MAX_HOLD  = 16,
    parameter int CNT_W     = 16
) (
    input logic                 clk,
    input logic                 resetn,
    clock_phase_monitor_if.slave mon
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int LOCK_W = (LOCK_REVS > 1) ? $clog2(LOCK_REVS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_REVS - 1);

    logic [0:3]        samp, prev, prev_n;
    mon_state_t        state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [LOCK_W-1:0] lock_cnt, lock_n;
    logic [1:0]        cur_phase, cur_n;
    logic              phase_strobe, strobe_n;
    logic [CNT_W-1:0]  rev_count, rev_n;
    logic              err_onehot, err_order, err_stall;
    logic              oh_n, ord_n, st_n;
    logic              new_oh, new_ord, new_st;
    logic [1:0]        samp_idx;
    logic              samp_valid;

    phase_decode u_decode (
        .onehot (samp),
        .idx    (samp_idx),
        .valid  (samp_valid)
    );

    always_comb begin
        prev_n   = prev;
        state_n  = state;
        hold_n   = hold_cnt;
        lock_n   = lock_cnt;
        cur_n    = cur_phase;
        strobe_n = 1'b0;
        rev_n    = rev_count;
        new_oh   = 1'b0;
        new_ord  = 1'b0;
        new_st   = 1'b0;

        if (state == UNLOCKED) begin
            hold_n = '0;
            if (samp_valid) begin
                prev_n  = samp;
                cur_n   = samp_idx;
                lock_n  = '0;
                state_n = LOCKING;
            end
        end else if (samp == prev) begin
            // hold_cnt counts repeats after the accepting sample, so the
            // phase has persisted hold_cnt + 2 samples once this one lands.
            hold_n = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;
            new_st = (hold_cnt >= HOLD_LIM);
        end else begin
            hold_n = '0;
            if (!samp_valid) begin
                new_oh = 1'b1;
            end else if (samp != next_phase(prev)) begin
                new_ord = 1'b1;
            end else if (state != FAULT) begin
                prev_n   = samp;
                cur_n    = samp_idx;
                strobe_n = 1'b1;
                if (samp == PH0) begin
                    if (state == LOCKING) begin
                        if (lock_cnt == LOCK_LAST) state_n = LOCKED;
                        else                       lock_n  = lock_cnt + 1'b1;
                    end else begin
                        rev_n = rev_count + 1'b1;
                    end
                end
            end
        end

        oh_n  = (err_onehot & ~mon.clear_err) | new_oh;
        ord_n = (err_order  & ~mon.clear_err) | new_ord;
        st_n  = (err_stall  & ~mon.clear_err) | new_st;

        // A fresh error wins over clear_err so the fault is never lost.
        if (new_oh || new_ord || new_st) begin
            state_n = FAULT;
        end else if (state == FAULT && mon.clear_err) begin
            state_n = UNLOCKED;
            prev_n  = '0;
            hold_n  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            samp         <= '0;
            prev         <= '0;
            state        <= UNLOCKED;
            hold_cnt     <= '0;
            lock_cnt     <= '0;
            cur_phase    <= '0;
            phase_strobe <= 1'b0;
            rev_count    <= '0;
            err_onehot   <= 1'b0;
            err_order    <= 1'b0;
            err_stall    <= 1'b0;
        end else begin
            samp         <= mon.phase_in;
            prev         <= prev_n;
            state        <= state_n;
            hold_cnt     <= hold_n;
            lock_cnt     <= lock_n;
            cur_phase    <= cur_n;
            phase_strobe <= strobe_n;
            rev_count    <= rev_n;
            err_onehot   <= oh_n;
            err_order    <= ord_n;
            err_stall    <= st_n;
        end
    end

    assign mon.cur_phase    = cur_phase;
    assign mon.phase_strobe = phase_strobe;
    assign mon.locked       = (state == LOCKED);
    assign mon.rev_count    = rev_count;
    assign mon.err_onehot   = err_onehot;
    assign mon.err_order    = err_order;
    assign mon.err_stall    = err_stall;

endmodule

// File: tb/tb_clock_phase_monitor.sv
// tb/tb_clock_phase_monitor.sv - directed bench for clock_phase_monitor
module tb_clock_phase_monitor;
    import clock_pkg::*;

    logic clk;
    logic resetn;
    int   compared;
    int   mismatched;
    logic [0:3] ph_tab [4];

    clock_phase_monitor_if #(.CNT_W(16)) mon_if ();

    clock_phase_monitor #(.LOCK_REVS(2), .MAX_HOLD(16), .CNT_W(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mon    (mon_if)
    );

    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    task automatic drive_phase(input logic [0:3] v, input int n, output int strobes);
        mon_if.phase_in = v;
        strobes = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (mon_if.phase_strobe === 1'b1) strobes++;
        end
    endtask

    task automatic do_reset();
        resetn           = 1'b0;
        mon_if.clear_err = 1'b0;
        mon_if.phase_in  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic run_revs(input int n);
        int s;
        for (int r = 0; r < n; r++) begin
            for (int p = 1; p <= 4; p++) drive_phase(ph_tab[p % 4], 5, s);
        end
    endtask

    task automatic lock_up();
        int s;
        drive_phase(PH0, 5, s);
        run_revs(2);
    endtask

    task automatic pulse_clear();
        mon_if.clear_err = 1'b1;
        @(posedge clk);
        #1;
        mon_if.clear_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if ({mon_if.cur_phase, mon_if.phase_strobe, mon_if.locked} !== 4'b0) begin mismatched++; $display("FAIL reset_status: got cur=%0d strobe=%0b locked=%0b want 0/0/0", mon_if.cur_phase, mon_if.phase_strobe, mon_if.locked); end
        compared++; if (mon_if.rev_count !== 16'd0) begin mismatched++; $display("FAIL reset_rev: got %0d want 0", mon_if.rev_count); end
        compared++; if ({mon_if.err_onehot, mon_if.err_order, mon_if.err_stall} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b want 000", {mon_if.err_onehot, mon_if.err_order, mon_if.err_stall}); end
    endtask

    task automatic test_lock();
        int s;
        do_reset();
        drive_phase(PH0, 5, s);
        compared++; if (s !== 0 || mon_if.cur_phase !== 2'd0 || mon_if.locked !== 1'b0) begin mismatched++; $display("FAIL first_load: strobes=%0d cur=%0d locked=%0b want 0/0/0", s, mon_if.cur_phase, mon_if.locked); end
        for (int r = 0; r < 2; r++) begin
            for (int p = 1; p <= 4; p++) begin
                drive_phase(ph_tab[p % 4], 5, s);
                compared++; if (s !== 1) begin mismatched++; $display("FAIL strobe_r%0d_p%0d: got %0d pulses want 1", r, p % 4, s); end
                compared++; if (mon_if.cur_phase !== 2'(p % 4)) begin mismatched++; $display("FAIL cur_r%0d_p%0d: got %0d want %0d", r, p % 4, mon_if.cur_phase, p % 4); end
            end
            compared++; if (mon_if.locked !== (r == 1)) begin mismatched++; $display("FAIL locked_after_rev%0d: got %0b want %0b", r + 1, mon_if.locked, r == 1); end
        end
        run_revs(3);
        compared++; if (mon_if.rev_count !== 16'd3) begin mismatched++; $display("FAIL rev_count_3: got %0d want 3", mon_if.rev_count); end
        compared++; if (mon_if.locked !== 1'b1) begin mismatched++; $display("FAIL still_locked: got %0b want 1", mon_if.locked); end
    endtask

    task automatic test_onehot_err();
        int s;
        drive_phase(PH1, 2, s);
        mon_if.phase_in = 4'b1100;
        @(posedge clk); #1;
        compared++; if (mon_if.err_onehot !== 1'b0 || mon_if.locked !== 1'b1) begin mismatched++; $display("FAIL onehot_early: err=%0b locked=%0b want 0/1", mon_if.err_onehot, mon_if.locked); end
        mon_if.phase_in = PH1;
        @(posedge clk); #1;
        compared++; if (mon_if.err_onehot !== 1'b1 || mon_if.locked !== 1'b0) begin mismatched++; $display("FAIL onehot_flag: err=%0b locked=%0b want 1/0", mon_if.err_onehot, mon_if.locked); end
        repeat (3) @(posedge clk);
        #1;
        compared++; if (mon_if.rev_count !== 16'd3 || mon_if.cur_phase !== 2'd1) begin mismatched++; $display("FAIL onehot_frozen: rev=%0d cur=%0d want 3/1", mon_if.rev_count, mon_if.cur_phase); end
        compared++; if ({mon_if.err_order, mon_if.err_stall} !== 2'b00) begin mismatched++; $display("FAIL onehot_others: got %b want 00", {mon_if.err_order, mon_if.err_stall}); end
        pulse_clear();
        compared++; if (mon_if.err_onehot !== 1'b0) begin mismatched++; $display("FAIL onehot_clear: got %0b want 0", mon_if.err_onehot); end
    endtask

    task automatic test_order_err();
        int s;
        do_reset();
        lock_up();
        run_revs(1);
        drive_phase(PH2, 5, s);
        compared++; if (mon_if.err_order !== 1'b1 || mon_if.locked !== 1'b0) begin mismatched++; $display("FAIL order_flag: err=%0b locked=%0b want 1/0", mon_if.err_order, mon_if.locked); end
        compared++; if (s !== 0 || mon_if.cur_phase !== 2'd0 || mon_if.rev_count !== 16'd1) begin mismatched++; $display("FAIL order_frozen: strobes=%0d cur=%0d rev=%0d want 0/0/1", s, mon_if.cur_phase, mon_if.rev_count); end
        pulse_clear();
        compared++; if (mon_if.err_order !== 1'b1 || mon_if.locked !== 1'b0) begin mismatched++; $display("FAIL clear_with_err: err=%0b locked=%0b want 1/0", mon_if.err_order, mon_if.locked); end
        mon_if.phase_in = PH0;
        repeat (2) @(posedge clk);
        #1;
        pulse_clear();
        compared++; if (mon_if.err_order !== 1'b0) begin mismatched++; $display("FAIL order_clear: got %0b want 0", mon_if.err_order); end
        drive_phase(PH0, 3, s);
        run_revs(1);
        compared++; if (mon_if.locked !== 1'b0) begin mismatched++; $display("FAIL relock_rev1: got %0b want 0", mon_if.locked); end
        run_revs(1);
        compared++; if (mon_if.locked !== 1'b1 || mon_if.rev_count !== 16'd1) begin mismatched++; $display("FAIL relock_rev2: locked=%0b rev=%0d want 1/1", mon_if.locked, mon_if.rev_count); end
    endtask

    task automatic test_stall();
        int s;
        do_reset();
        lock_up();
        drive_phase(PH1, 16, s);
        compared++; if (s !== 1) begin mismatched++; $display("FAIL hold16_strobe: got %0d want 1", s); end
        drive_phase(PH2, 5, s);
        drive_phase(PH3, 5, s);
        drive_phase(PH0, 5, s);
        compared++; if (mon_if.err_stall !== 1'b0 || mon_if.locked !== 1'b1) begin mismatched++; $display("FAIL hold16_ok: stall=%0b locked=%0b want 0/1", mon_if.err_stall, mon_if.locked); end
        drive_phase(PH1, 17, s);
        compared++; if (mon_if.err_stall !== 1'b0) begin mismatched++; $display("FAIL hold17_early: got %0b want 0", mon_if.err_stall); end
        drive_phase(PH2, 1, s);
        compared++; if (mon_if.err_stall !== 1'b1 || mon_if.locked !== 1'b0) begin mismatched++; $display("FAIL hold17_stall: stall=%0b locked=%0b want 1/0", mon_if.err_stall, mon_if.locked); end
        drive_phase(PH2, 2, s);
        compared++; if ({mon_if.err_onehot, mon_if.err_order} !== 2'b00) begin mismatched++; $display("FAIL stall_others: got %b want 00", {mon_if.err_onehot, mon_if.err_order}); end
    endtask

    task automatic test_idle_zero();
        int s;
        do_reset();
        drive_phase(4'b0000, 10, s);
        compared++; if ({mon_if.err_onehot, mon_if.err_order, mon_if.err_stall, mon_if.locked} !== 4'b0000) begin mismatched++; $display("FAIL idle_zero: got %b want 0000", {mon_if.err_onehot, mon_if.err_order, mon_if.err_stall, mon_if.locked}); end
        drive_phase(PH0, 5, s);
        run_revs(1);
        compared++; if (mon_if.locked !== 1'b0) begin mismatched++; $display("FAIL idle_rev1: got %0b want 0", mon_if.locked); end
        run_revs(1);
        compared++; if (mon_if.locked !== 1'b1 || mon_if.cur_phase !== 2'd0) begin mismatched++; $display("FAIL idle_rev2: locked=%0b cur=%0d want 1/0", mon_if.locked, mon_if.cur_phase); end
    endtask

    task automatic test_midrev_reset();
        int s;
        do_reset();
        lock_up();
        run_revs(5);
        compared++; if (mon_if.rev_count !== 16'd5) begin mismatched++; $display("FAIL rev_count_5: got %0d want 5", mon_if.rev_count); end
        drive_phase(PH1, 1, s);
        resetn = 1'b0;
        @(posedge clk); #1;
        compared++; if ({mon_if.cur_phase, mon_if.phase_strobe, mon_if.locked, mon_if.err_onehot, mon_if.err_order, mon_if.err_stall} !== 7'b0) begin mismatched++; $display("FAIL midrev_outputs: got %b want 0000000", {mon_if.cur_phase, mon_if.phase_strobe, mon_if.locked, mon_if.err_onehot, mon_if.err_order, mon_if.err_stall}); end
        compared++; if (mon_if.rev_count !== 16'd0) begin mismatched++; $display("FAIL midrev_rev: got %0d want 0", mon_if.rev_count); end
        resetn = 1'b1;
        drive_phase(PH1, 4, s);
        compared++; if (s !== 0 || mon_if.cur_phase !== 2'd1 || mon_if.locked !== 1'b0) begin mismatched++; $display("FAIL midrev_unlocked_load: strobes=%0d cur=%0d locked=%0b want 0/1/0", s, mon_if.cur_phase, mon_if.locked); end
        drive_phase(PH2, 5, s);
        compared++; if (s !== 1 || mon_if.cur_phase !== 2'd2) begin mismatched++; $display("FAIL midrev_next: strobes=%0d cur=%0d want 1/2", s, mon_if.cur_phase); end
    endtask

    initial begin
        compared         = 0;
        mismatched       = 0;
        ph_tab[0]        = PH0;
        ph_tab[1]        = PH1;
        ph_tab[2]        = PH2;
        ph_tab[3]        = PH3;
        resetn           = 1'b0;
        mon_if.phase_in  = 4'b0000;
        mon_if.clear_err = 1'b0;
        test_reset();
        test_lock();
        test_onehot_err();
        test_order_err();
        test_stall();
        test_idle_zero();
        test_midrev_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
